// File: rtl/serial_shifter.sv
// serial_shifter: bit-serial shifter, one 1-bit step per clock, valid/ready on both sides
// Ports: clk, rst (synchronous, active-high)
//        in_valid_i/in_ready_o/in_data_i/in_shamt_i/in_op_i  request (op 00 LSR, 01 ASR, 10 LSL, 11 ROR)
//        out_valid_o/out_ready_i/out_data_o                  result, held stable until taken
//        busy_o                                              high in SHIFT or DONE
// Optional: SERIAL_SHIFTER_STICKY_EN adds out_sticky_o, the OR of every bit shifted out by LSR/ASR.
module serial_shifter #(
   parameter int WIDTH   = 4,
   parameter int SHAMT_W = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid_i,
   output logic               in_ready_o,
   input  logic [WIDTH-1:0]   in_data_i,
   input  logic [SHAMT_W-1:0] in_shamt_i,
   input  logic [1:0]         in_op_i,
   output logic               out_valid_o,
   input  logic               out_ready_i,
   output logic [WIDTH-1:0]   out_data_o,
   output logic               busy_o
`ifdef SERIAL_SHIFTER_STICKY_EN
   ,
   output logic               out_sticky_o
`endif
);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   state_t             state_q, state_d;
   logic [WIDTH-1:0]   sr_q, sr_d, step;
   logic [SHAMT_W-1:0] cnt_q, cnt_d;
   logic [1:0]         op_q, op_d;
   logic               accept, fill;

   assign accept = (state_q == IDLE) && in_valid_i;

   // Bit entering at the MSB for the right-shifting ops; LSL has its own form.
   always_comb begin
      fill = op_q == 2'b00 ? 1'b0 : op_q == 2'b01 ? sr_q[WIDTH-1] : sr_q[0];
      step = op_q == 2'b10 ? {sr_q[WIDTH-2:0], 1'b0} : {fill, sr_q[WIDTH-1:1]};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         sr_q    <= '0;
         cnt_q   <= '0;
         op_q    <= 2'b00;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_valid_i) state_d = (in_shamt_i != '0) ? SHIFT : DONE;
         SHIFT:   if (cnt_q == SHAMT_W'(1)) state_d = DONE;
         DONE:    if (out_ready_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      sr_d  = accept ? in_data_i  : (state_q == SHIFT) ? step : sr_q;
      cnt_d = accept ? in_shamt_i : (state_q == SHIFT) ? cnt_q - SHAMT_W'(1) : cnt_q;
      op_d  = accept ? in_op_i    : op_q;
   end

   always_comb begin
      in_ready_o  = state_q == IDLE;
      out_valid_o = state_q == DONE;
      busy_o      = state_q != IDLE;
      out_data_o  = sr_q;
   end

`ifdef SERIAL_SHIFTER_STICKY_EN
   logic sticky_q, sticky_d;

   // Only right shifts by LSR/ASR (op[1]==0) lose information out of the LSB.
   always_comb sticky_d = accept ? 1'b0 : (state_q == SHIFT && !op_q[1]) ? sticky_q | sr_q[0] : sticky_q;

   always_ff @(posedge clk) begin
      if (rst) sticky_q <= 1'b0;
      else     sticky_q <= sticky_d;
   end

   assign out_sticky_o = sticky_q;
`endif
endmodule

// File: tb/tb_serial_shifter.sv
// tb_serial_shifter: directed bench with a latency/arithmetic model for serial_shifter
module tb_serial_shifter;
   logic       clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
   logic [3:0] in_data = '0;
   logic [1:0] in_shamt = '0, in_op = '0;
   logic       in_ready, out_valid, busy;
   logic [3:0] out_data;
`ifdef SERIAL_SHIFTER_STICKY_EN
   logic       out_sticky;
`endif
   int         total = 0, bad = 0;
   bit         chk_en = 1'b0;

   serial_shifter #(.WIDTH(4), .SHAMT_W(2)) dut (
      .clk(clk), .rst(rst),
      .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
      .in_shamt_i(in_shamt), .in_op_i(in_op),
      .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
      .busy_o(busy)
`ifdef SERIAL_SHIFTER_STICKY_EN
      , .out_sticky_o(out_sticky)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic int mres(input int d, input int s, input int o);
      int sv;
      sv = (d >= 8) ? d - 16 : d;
      case (o)
         0:       return d >> s;
         1:       return (sv >>> s) & 15;
         2:       return (d << s) & 15;
         default: return ((d >> (s % 4)) | (d << (4 - s % 4))) & 15;
      endcase
   endfunction

   function automatic int mst(input int d, input int s, input int o);
      return (o < 2 && (d & ((1 << s) - 1)) != 0) ? 1 : 0;
   endfunction

   // Model: a request finishes in_shamt edges after the edge that accepts it.
   bit m_busy = 0, m_valid = 0;
   int m_wait = 0, m_res = 0, m_st = 0;
   always @(posedge clk) begin
      if (rst) begin
         m_busy = 0; m_valid = 0;
      end else if (!m_busy) begin
         if (in_valid) begin
            m_busy = 1; m_wait = int'(in_shamt); m_valid = (in_shamt == 0);
            m_res = mres(int'(in_data), int'(in_shamt), int'(in_op));
            m_st = mst(int'(in_data), int'(in_shamt), int'(in_op));
         end
      end else if (!m_valid) begin
         m_wait--;
         if (m_wait == 0) m_valid = 1;
      end else if (out_ready) begin
         m_busy = 0; m_valid = 0;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("cmp in_ready", int'(in_ready), int'(!m_busy));
         chk("cmp busy", int'(busy), int'(m_busy));
         chk("cmp out_valid", int'(out_valid), int'(m_valid));
         if (m_valid) begin
            chk("cmp out_data", int'(out_data), m_res);
`ifdef SERIAL_SHIFTER_STICKY_EN
            chk("cmp sticky", int'(out_sticky), m_st);
`endif
         end
      end
   end

   task automatic req(input logic [3:0] d, input logic [1:0] s, input logic [1:0] o,
                      input int exp, input int est, input string nm);
      int n;
      n = 0;
      while (!in_ready && n < 50) begin @(posedge clk); #2; n++; end
      chk({nm, " ready"}, int'(in_ready), 1);
      in_valid = 1'b1; in_data = d; in_shamt = s; in_op = o;
      @(posedge clk); #2;
      in_valid = 1'b0; in_data = 4'($urandom); in_shamt = 2'($urandom); in_op = 2'($urandom);
      n = 0;
      while (!out_valid && n < 20) begin @(posedge clk); #2; n++; end
      chk({nm, " latency"}, n, int'(s));
      chk({nm, " data"}, int'(out_data), exp);
`ifdef SERIAL_SHIFTER_STICKY_EN
      chk({nm, " sticky"}, int'(out_sticky), est);
`else
      if (est > 1) $display("sticky expectation ignored");
`endif
      if (out_ready) begin
         @(posedge clk); #2;
         chk({nm, " return"}, int'(in_ready), 1);
      end
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      chk("rst in_ready", int'(in_ready), 1);
      chk("rst out_valid", int'(out_valid), 0);
      chk("rst busy", int'(busy), 0);
      chk("rst out_data", int'(out_data), 0);
      chk_en = 1'b1;
      req(4'b1001, 2'd1, 2'b01, 4'b1100, 1, "asr -7>>>1");
      req(4'b1001, 2'd1, 2'b00, 4'b0100, 1, "lsr 9>>1");
      req(4'b0110, 2'd1, 2'b00, 4'b0011, 0, "lsr 6>>1");
      req(4'b0110, 2'd3, 2'b11, 4'b1100, 0, "ror 6 by 3");
      req(4'b0110, 2'd3, 2'b10, 4'b0000, 0, "lsl 6<<3");
      for (int o = 0; o < 4; o++) req(4'b1010, 2'd0, 2'(o), 4'b1010, 0, "shamt0");
      out_ready = 1'b0;
      req(4'b1001, 2'd2, 2'b01, 4'b1110, 1, "bp asr");
      repeat (5) begin
         @(posedge clk); #2;
         chk("bp hold valid", int'(out_valid), 1);
         chk("bp hold data", int'(out_data), 4'b1110);
         chk("bp in_ready low", int'(in_ready), 0);
      end
      out_ready = 1'b1;
      @(posedge clk); #2;
      chk("bp released in_ready", int'(in_ready), 1);
      chk("bp released valid", int'(out_valid), 0);
      in_valid = 1'b1; in_data = 4'b1001; in_shamt = 2'd3; in_op = 2'b01;
      @(posedge clk); #2 in_valid = 1'b0;
      @(posedge clk); #2 rst = 1'b1;
      @(posedge clk); #2 rst = 1'b0;
      chk("midrst out_valid", int'(out_valid), 0);
      chk("midrst out_data", int'(out_data), 0);
      chk("midrst busy", int'(busy), 0);
      chk("midrst in_ready", int'(in_ready), 1);
      req(4'b1000, 2'd3, 2'b00, 4'b0001, 0, "after rst lsr");
      req(4'b1101, 2'd3, 2'b01, 4'b1111, 1, "asr all sign");
      foreach (in_data[i]) begin end
      for (int o = 0; o < 4; o++)
         for (int s = 0; s < 4; s++)
            for (int k = 0; k < 2; k++) begin
               logic [3:0] d;
               d = k ? 4'b0101 : 4'b1011;
               req(d, 2'(s), 2'(o), mres(int'(d), s, o), mst(int'(d), s, o), "sweep");
            end
      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/serial_shifter.md
Name: serial_shifter

Overview:
- Multi-cycle bit-serial shift unit. Accepts one operand plus a shift amount and op code over a valid/ready handshake.
- Performs one 1-bit shift per clock, then holds the result on a valid/ready output port.
- Sits directly upstream of the result-display / checking stage. That stage consumes the logical and arithmetic shift results of signed and unsigned 4-bit operands.
- Replaces the single-cycle shift operators with a sequential, area-cheap datapath.

Parameters:
- WIDTH, 4, operand and result width in bits (min 2).
- SHAMT_W, 2, width of the shift-amount field; max shift = 2**SHAMT_W - 1.

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand request valid.
- in_ready  output  1  block can accept a request (high only in IDLE).
- in_data  input  WIDTH  operand; its sign is taken from the op code, not from the port.
- in_shamt  input  SHAMT_W  shift amount, unsigned.
- in_op  input  2  op code: 00 LSR (zero fill), 01 ASR (MSB fill), 10 LSL (zero fill), 11 ROR (rotate right).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_data  output  WIDTH  shifted result.
- busy  output  1  high in SHIFT or DONE.

Behaviour:
- Reset: on rst=1 at a rising edge the block does the following, regardless of state (this aborts any operation in flight):
  - state <= IDLE;
  - shift register <= 0; counter <= 0; op <= 00;
  - out_valid=0, out_data=0, busy=0, in_ready=1 in the following cycle.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: latch in_data into the shift register, in_shamt into the counter, and in_op.
  - Next state is SHIFT if in_shamt!=0, else DONE.
  - in_valid=0 -> stay in IDLE. Inputs are ignored outside IDLE.
- SHIFT, one 1-bit step per edge:
  - LSR: {0, r[W-1:1]}.
  - ASR: {r[W-1], r[W-1:1]}.
  - LSL: {r[W-2:0], 0}.
  - ROR: {r[0], r[W-1:1]}.
  - Counter decrements each step. When the counter equals 1 at the edge, the final step is taken and next state is DONE.
- DONE:
  - out_valid=1 and out_data = shift register; both are stable while out_ready=0.
  - On an edge with out_ready=1 -> IDLE.
  - in_ready returns high the cycle after that edge; there is no same-cycle accept/return.
- Latency: out_valid asserts in the cycle after the accept edge plus in_shamt further edges, i.e. max(1, in_shamt+1) cycles after the accept cycle. Throughput: one request per (latency + 1) cycles minimum.
- Widths: all shifts are within WIDTH; bits shifted out are discarded.
- Shift amounts: in_shamt >= WIDTH is legal.
  - LSR/LSL give 0.
  - ASR gives all-sign.
  - ROR gives rotation by in_shamt mod WIDTH; the steps are performed literally.
- out_data is registered only; there is no combinational path from in_* to out_*.
- Simultaneous rst and handshake: reset wins.
- in_valid high while not in IDLE: no effect; the requester holds it until in_ready.

Optional Feature:
- Macro: SERIAL_SHIFTER_STICKY_EN.
- When defined:
  - Adds output out_sticky (1 bit), valid with out_data.
  - out_sticky = OR of every bit shifted out of the LSB during LSR/ASR steps; it stays 0 for LSL and ROR.
  - The sticky flop clears on accept and on rst.
- When undefined: port and logic are absent; behaviour is otherwise identical.

Test Plan:
- Request: in_data=4'b1001 (-7), op=ASR, shamt=1 -> out_data=4'b1100 (-4), out_valid 2 cycles after the accept cycle; with STICKY_EN, out_sticky=1.
- Request: in_data=4'b1001, op=LSR, shamt=1 -> out_data=4'b0100 (4). Then in_data=4'b0110 (6), LSR, shamt=1 -> 4'b0011 (3), sticky=0.
- Request: in_data=4'b0110, op=ROR, shamt=3 -> out_data=4'b1100. Then op=LSL, shamt=3 -> 4'b0000; busy high for 4 cycles.
- Request: shamt=0 with any op, in_data=4'b1010 -> out_data=4'b1010, out_valid in the cycle after accept.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> out_data/out_valid held, in_ready=0 throughout. On out_ready=1 -> IDLE, in_ready=1 next cycle.
- Reset mid-SHIFT: ASR shamt=3 accepted, rst=1 on the 2nd SHIFT edge -> next cycle out_valid=0, out_data=0, busy=0, in_ready=1. A new request then completes correctly.
